// File: rtl/hazard_ctrl.sv
// Pipeline hazard/stall controller for the 5-stage core.
// Handles load-use, dcache/icache waits, taken-branch squash and halt,
// driving latch enables/flushes with zero latency from state + inputs.
module hazard_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             ihit,
  input  logic             dhit,
  input  logic             mem_dREN,
  input  logic             mem_dWEN,
  input  logic             ex_memRead,
  input  logic [4:0]       ex_rt,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_useRt,
  input  logic             branch_taken,
  input  logic             wb_halt,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             idex_en,
  output logic             exmem_en,
  output logic             memwb_en,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             memwb_flush,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef enum logic [1:0] {RUN = 2'd0, DWAIT = 2'd1, HALT = 2'd2} state_t;

  state_t           r_state;
  logic             r_flush_pend;
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_cnt;

  state_t w_next_state;
  logic   w_next_fp;
  logic   w_flush_inc;
  logic   w_dreq;
  logic   w_luse;

  assign w_dreq = mem_dREN | mem_dWEN;
  // ex_rt==0 never hazards: $zero is never really written.
  assign w_luse = ex_memRead && (ex_rt != 5'd0) &&
                  ((ex_rt == id_rs) || (id_useRt && (ex_rt == id_rt)));

  // Priority resolver: first matching condition owns the enables/flushes.
  always_comb begin
    pc_en        = 1'b1;
    ifid_en      = 1'b1;
    idex_en      = 1'b1;
    exmem_en     = 1'b1;
    memwb_en     = 1'b1;
    ifid_flush   = 1'b0;
    idex_flush   = 1'b0;
    memwb_flush  = 1'b0;
    halted       = 1'b0;
    w_next_state = r_state;
    w_next_fp    = r_flush_pend;
    w_flush_inc  = 1'b0;
    if (!nRST) begin
      {pc_en, ifid_en, idex_en, exmem_en, memwb_en} = 5'b0;
    end else if (r_state == HALT) begin
      {pc_en, ifid_en, idex_en, exmem_en, memwb_en} = 5'b0;
      halted = 1'b1;
    end else if (wb_halt) begin
      {pc_en, ifid_en, idex_en, exmem_en, memwb_en} = 5'b0;
      w_next_state = HALT;
    end else if (w_dreq && !dhit) begin
      // Freeze everything up to MEM; WB gets bubbles until the access lands.
      {pc_en, ifid_en, idex_en, exmem_en} = 4'b0;
      memwb_flush  = 1'b1;
      w_next_state = DWAIT;
    end else begin
      w_next_state = RUN;
      if (branch_taken) begin
        ifid_flush  = 1'b1;
        idex_flush  = 1'b1;
        w_flush_inc = 1'b1;
        // An outstanding fetch cannot be aborted; remember to drop it.
        if (!ihit) w_next_fp = 1'b1;
      end else if (r_flush_pend && ihit) begin
        // Stale wrong-path instruction arrives; PC already holds the target.
        ifid_flush = 1'b1;
        pc_en      = 1'b0;
        w_next_fp  = 1'b0;
      end else if (w_luse) begin
        pc_en      = 1'b0;
        ifid_en    = 1'b0;
        idex_flush = 1'b1;
      end else if (!ihit) begin
        pc_en      = 1'b0;
        ifid_flush = 1'b1;
      end
    end
  end

  // State, flush-pending bit and saturating counters.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      r_state      <= RUN;
      r_flush_pend <= 1'b0;
      r_stall_cnt  <= '0;
      r_flush_cnt  <= '0;
    end else begin
      r_state      <= w_next_state;
      r_flush_pend <= w_next_fp;
      if ((r_state != HALT) && !pc_en && (r_stall_cnt != '1))
        r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      if (w_flush_inc && (r_flush_cnt != '1))
        r_flush_cnt <= r_flush_cnt + CNT_W'(1);
    end
  end

  assign stall_cnt = r_stall_cnt;
  assign flush_cnt = r_flush_cnt;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: a stateless vector table plus
// hand-written multi-cycle sequences (dcache wait, pending fetch, halt,
// counter saturation on a narrow second instance).
module tb_hazard_ctrl;

  logic CLK = 1'b0;
  logic nRST, ihit, dhit, mem_dREN, mem_dWEN, ex_memRead, id_useRt, branch_taken, wb_halt;
  logic [4:0] ex_rt, id_rs, id_rt;
  logic pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush, memwb_flush, halted;
  logic [15:0] stall_cnt, flush_cnt;
  logic s_pc_en, s_ifid_en, s_idex_en, s_exmem_en, s_memwb_en;
  logic s_ifid_flush, s_idex_flush, s_memwb_flush, s_halted;
  logic [1:0] s_stall_cnt, s_flush_cnt;
  logic [8:0] outs;

  int checks = 0;
  int failures = 0;

  always #5 CLK = ~CLK;

  hazard_ctrl #(.CNT_W(16)) dut (
    .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit), .mem_dREN(mem_dREN), .mem_dWEN(mem_dWEN),
    .ex_memRead(ex_memRead), .ex_rt(ex_rt), .id_rs(id_rs), .id_rt(id_rt), .id_useRt(id_useRt),
    .branch_taken(branch_taken), .wb_halt(wb_halt),
    .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en), .exmem_en(exmem_en), .memwb_en(memwb_en),
    .ifid_flush(ifid_flush), .idex_flush(idex_flush), .memwb_flush(memwb_flush), .halted(halted),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt));

  hazard_ctrl #(.CNT_W(2)) dut_sat (
    .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit), .mem_dREN(mem_dREN), .mem_dWEN(mem_dWEN),
    .ex_memRead(ex_memRead), .ex_rt(ex_rt), .id_rs(id_rs), .id_rt(id_rt), .id_useRt(id_useRt),
    .branch_taken(branch_taken), .wb_halt(wb_halt),
    .pc_en(s_pc_en), .ifid_en(s_ifid_en), .idex_en(s_idex_en), .exmem_en(s_exmem_en),
    .memwb_en(s_memwb_en), .ifid_flush(s_ifid_flush), .idex_flush(s_idex_flush),
    .memwb_flush(s_memwb_flush), .halted(s_halted),
    .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt));

  // {pc, ifid, idex, exmem, memwb enables, ifid/idex/memwb flush, halted}
  assign outs = {pc_en, ifid_en, idex_en, exmem_en, memwb_en,
                 ifid_flush, idex_flush, memwb_flush, halted};

  typedef struct {
    logic       ihit, dhit, dren, dwen, mr;
    logic [4:0] ex_rt, rs, rt;
    logic       use_rt, br, halt;
    logic [8:0] exp;
  } vec_t;

  localparam logic [8:0] E_RUN  = 9'b11111_000_0;
  localparam logic [8:0] E_LUSE = 9'b00111_010_0;
  localparam logic [8:0] E_IMIS = 9'b01111_100_0;
  localparam logic [8:0] E_DW   = 9'b00001_001_0;
  localparam logic [8:0] E_BR   = 9'b11111_110_0;
  localparam logic [8:0] E_OFF  = 9'b00000_000_0;
  localparam logic [8:0] E_HLT  = 9'b00000_000_1;

  function automatic vec_t mk(logic ih, logic dh, logic dr, logic dw, logic mr,
                              logic [4:0] er, logic [4:0] rs, logic [4:0] rt,
                              logic ur, logic br, logic hl, logic [8:0] exp);
    vec_t v;
    v.ihit = ih; v.dhit = dh; v.dren = dr; v.dwen = dw; v.mr = mr;
    v.ex_rt = er; v.rs = rs; v.rt = rt; v.use_rt = ur; v.br = br; v.halt = hl; v.exp = exp;
    return v;
  endfunction

  function automatic vec_t idle(logic ih);
    return mk(ih, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, E_RUN);
  endfunction

  task automatic check_outs(string name, logic [8:0] exp);
    checks++;
    if (outs !== exp) begin
      failures++;
      $display("FAIL %s: outs=%b expected=%b", name, outs, exp);
    end
  endtask

  task automatic check_val(string name, logic [15:0] act, logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got=%0d expected=%0d", name, act, exp);
    end
  endtask

  // Drive at negedge, check combinational outputs 1ns later.
  task automatic step(vec_t v, string name, logic [8:0] exp);
    @(negedge CLK);
    ihit = v.ihit; dhit = v.dhit; mem_dREN = v.dren; mem_dWEN = v.dwen;
    ex_memRead = v.mr; ex_rt = v.ex_rt; id_rs = v.rs; id_rt = v.rt;
    id_useRt = v.use_rt; branch_taken = v.br; wb_halt = v.halt;
    #1 check_outs(name, exp);
  endtask

  task automatic after_edge();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    @(negedge CLK);
    nRST = 1'b0;
    ihit = 1'b1; dhit = 0; mem_dREN = 0; mem_dWEN = 0; ex_memRead = 0;
    ex_rt = 0; id_rs = 0; id_rt = 0; id_useRt = 0; branch_taken = 0; wb_halt = 0;
    #1 check_outs("reset_c0", E_OFF);
    @(negedge CLK);
    #1 check_outs("reset_c1", E_OFF);
    @(negedge CLK);
    nRST = 1'b1;
    #1;
    check_val("reset_stall_cnt", stall_cnt, 16'd0);
    check_val("reset_flush_cnt", flush_cnt, 16'd0);
    check_outs("reset_run", E_RUN);
  endtask

  vec_t tbl[10];

  initial begin
    tbl[0] = idle(1);
    tbl[1] = mk(1, 0, 0, 0, 1, 5'd5, 5'd5, 5'd0, 0, 0, 0, E_LUSE);
    tbl[2] = mk(1, 0, 0, 0, 1, 5'd0, 5'd0, 5'd0, 0, 0, 0, E_RUN);
    tbl[3] = mk(1, 0, 0, 0, 1, 5'd7, 5'd3, 5'd7, 1, 0, 0, E_LUSE);
    tbl[4] = mk(1, 0, 0, 0, 1, 5'd7, 5'd3, 5'd7, 0, 0, 0, E_RUN);
    tbl[5] = mk(1, 0, 0, 0, 0, 5'd5, 5'd5, 5'd5, 1, 0, 0, E_RUN);
    tbl[6] = idle(0); tbl[6].exp = E_IMIS;
    tbl[7] = mk(1, 0, 1, 0, 1, 5'd5, 5'd5, 5'd0, 0, 0, 0, E_DW);
    tbl[8] = mk(0, 1, 0, 1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, E_IMIS);
    tbl[9] = mk(1, 0, 0, 0, 1, 5'd5, 5'd5, 5'd0, 0, 1, 0, E_BR);

    nRST = 1'b0;
    do_reset();
    for (int i = 0; i < 10; i++) step(tbl[i], $sformatf("vec%0d", i), tbl[i].exp);

    // Load-use: single bubble, then proceed.
    do_reset();
    step(mk(1, 0, 0, 0, 1, 5'd5, 5'd5, 5'd0, 0, 0, 0, 0), "luse_stall", E_LUSE);
    after_edge();
    check_val("luse_stall_cnt", stall_cnt, 16'd1);
    step(idle(1), "luse_resume", E_RUN);

    // Dcache wait of 3 cycles.
    do_reset();
    for (int i = 0; i < 3; i++)
      step(mk(1, 0, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0), $sformatf("dwait_c%0d", i), E_DW);
    step(mk(1, 1, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0), "dwait_hit", E_RUN);
    after_edge();
    check_val("dwait_stall_cnt", stall_cnt, 16'd3);

    // Taken branch with outstanding fetch.
    do_reset();
    step(mk(0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 1, 0, 0), "bpend_c0", E_BR);
    after_edge();
    check_val("bpend_flush_cnt", flush_cnt, 16'd1);
    step(idle(0), "bpend_c1", E_IMIS);
    step(idle(1), "bpend_c2_drop", E_IMIS);
    step(idle(1), "bpend_c3_clear", E_RUN);
    after_edge();
    check_val("bpend_stall_cnt", stall_cnt, 16'd2);

    // Branch held in EX across a dcache wait.
    do_reset();
    step(mk(1, 0, 0, 1, 0, 5'd0, 5'd0, 5'd0, 0, 1, 0, 0), "bdw_c0", E_DW);
    step(mk(1, 0, 0, 1, 0, 5'd0, 5'd0, 5'd0, 0, 1, 0, 0), "bdw_c1", E_DW);
    after_edge();
    check_val("bdw_no_flush", flush_cnt, 16'd0);
    step(mk(1, 1, 0, 1, 0, 5'd0, 5'd0, 5'd0, 0, 1, 0, 0), "bdw_hit", E_BR);
    after_edge();
    check_val("bdw_flush_cnt", flush_cnt, 16'd1);

    // flush_pend survives a dcache wait.
    do_reset();
    step(mk(0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 1, 0, 0), "fpdw_br", E_BR);
    step(mk(1, 0, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0), "fpdw_wait", E_DW);
    step(mk(1, 1, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0), "fpdw_drop", E_IMIS);
    step(idle(1), "fpdw_run", E_RUN);

    // Halt: sticky, counters frozen.
    do_reset();
    step(mk(1, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 1, 0), "halt_c0", E_OFF);
    for (int i = 0; i < 3; i++) step(idle(0), $sformatf("halt_sticky%0d", i), E_HLT);
    after_edge();
    check_val("halt_stall_frozen", stall_cnt, 16'd1);

    // Saturation on the 2-bit instance.
    do_reset();
    for (int i = 0; i < 5; i++) step(idle(0), $sformatf("sat_imis%0d", i), E_IMIS);
    after_edge();
    check_val("sat_stall_wide", stall_cnt, 16'd5);
    check_val("sat_stall_narrow", {14'd0, s_stall_cnt}, 16'd3);
    for (int i = 0; i < 5; i++)
      step(mk(1, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 1, 0, 0), $sformatf("sat_br%0d", i), E_BR);
    after_edge();
    check_val("sat_flush_wide", flush_cnt, 16'd5);
    check_val("sat_flush_narrow", {14'd0, s_flush_cnt}, 16'd3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Pipeline hazard/stall controller for the 5-stage MIPS core; sits beside and directly upstream of the forwarding unit.
- Resolves what forwarding cannot: load-use, I/D-cache waits, taken-branch squash, halt.
- Drives enable/flush of PC, IF/ID, ID/EX, EX/MEM, MEM/WB latches.
- Keeps a sticky flush-pending bit for non-abortable icache fetches, plus saturating performance counters.

Parameters:
- CNT_W, 16, width of stall_cnt and flush_cnt.

Ports:
- CLK  in  1  clock; all state updates on the rising edge.
- nRST  in  1  synchronous reset, active-low.
- ihit  in  1  icache returned instruction this cycle.
- dhit  in  1  dcache completed the MEM-stage access this cycle.
- mem_dREN, mem_dWEN  in  1 each  MEM-stage load/store request.
- ex_memRead  in  1  EX instruction is a load.
- ex_rt  in  5  EX load destination register.
- id_rs, id_rt  in  5 each  ID source registers.
- id_useRt  in  1  ID instruction reads rt.
- branch_taken  in  1  EX resolved taken branch/jump redirect.
- wb_halt  in  1  HALT reached WB.
- pc_en, ifid_en, idex_en, exmem_en, memwb_en  out  1 each  latch enables.
- ifid_flush, idex_flush, memwb_flush  out  1 each  load bubble (nop, control zeroed) on the edge.
- halted  out  1  core halted, sticky.
- stall_cnt  out  CNT_W  cycles with pc_en=0 while not halted.
- flush_cnt  out  CNT_W  taken-branch squash events.

Behaviour:
- State: RUN, DWAIT, HALT (2-bit reg), flush_pend (1 bit). Reset: RUN, flush_pend=0, counters 0.
- While nRST=0: all enables 0, all flushes 0, halted=0.
- Outputs are combinational from state+inputs; zero latency.
- Default (no condition): all enables 1, flushes 0.
- dreq = mem_dREN|mem_dWEN.
- luse = ex_memRead & ex_rt!=0 & (ex_rt==id_rs | (id_useRt & ex_rt==id_rt)).
- Priority per cycle, first match wins:
  1. State HALT: all enables 0, halted=1; stays until reset.
  2. wb_halt: all enables 0; next state HALT.
  3. dreq & !dhit: pc/ifid/idex/exmem en=0; memwb_en=1, memwb_flush=1. Next state DWAIT; stay while !dhit. Cycle with dhit proceeds as the following rules and returns to RUN.
  4. branch_taken: pc_en=1 (loads target), ifid_flush=1, idex_flush=1, flush_cnt++. If !ihit, set flush_pend.
  5. flush_pend & ihit: stale fetch discarded: ifid_flush=1, pc_en=0 (PC already holds target); clear flush_pend.
  6. luse: pc_en=0, ifid_en=0, idex_flush=1. Exactly one bubble, since next cycle EX holds a nop.
  7. !ihit: pc_en=0, ifid_flush=1, downstream enabled.
- Precedence interactions:
  - DWAIT holds a pending branch in EX; it is re-evaluated on dhit.
  - flush_pend persists across DWAIT.
  - A branch during flush_pend keeps it set.
- Counters saturate at all-ones; no wrap. stall_cnt increments in any non-HALT, nRST=1 cycle with pc_en=0.
- Reset mid-DWAIT or mid-flush_pend clears everything on the next edge.

Test Plan:
- Reset: nRST=0 two cycles with ihit=1 → all enables 0; after release, RUN with ihit=1 → all enables 1, counters 0.
- Load-use: ex_memRead=1, ex_rt=5, id_rs=5, ihit=1 → one cycle pc_en=0, ifid_en=0, idex_flush=1, stall_cnt=1. Repeat with ex_rt=0 → no stall.
- Dcache wait: mem_dREN=1, dhit=0 for 3 cycles then 1 → 3 cycles of pc/ifid/idex/exmem en=0 with memwb_flush=1; then normal; stall_cnt=3.
- Branch with pending fetch: branch_taken=1, ihit=0, then ihit=0, then ihit=1 → cycle0 pc_en=1, ifid_flush=1, idex_flush=1, flush_cnt=1; cycle2 ifid_flush=1, pc_en=0, flush_pend cleared.
- Branch during DWAIT: branch_taken=1, mem_dWEN=1, dhit=0 for 2 cycles → no flush; on dhit cycle the branch squash occurs, flush_cnt=1.
- Halt: wb_halt=1 → enables 0; halted=1 next cycle and sticky; stall_cnt frozen; CNT_W=2 saturation run stops at 3.
